// File: rtl/add_sub_pkg.sv
// Shared types for the serial add/sub engine: FSM state encoding and op codes.
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/digit_add_slice.sv
// One DIGIT-wide ripple slice: sum, carry out, and carry into its top bit.
module digit_add_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};

  // The carry into the top bit is recovered from that bit's sum and operands.
  assign c_msb = sum[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_add_sub_unit.sv
// Multi-cycle two's-complement add/sub, DIGIT bits per cycle LSB first, with
// carry / signed-overflow / zero flags.
module serial_add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload until then, and ready never depends on valid.

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_add_sub_unit: illegal WIDTH/DIGIT combination");
  end

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_nxt;
  logic             carry;
  logic             carry_q;
  logic             ovf_q;
  logic             zero_q;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;
  logic             accept;
  logic             last_digit;

  digit_add_slice #(.DIGIT(DIGIT)) u_slice (
    .x     (a_sr[DIGIT-1:0]),
    .y     (b_sr[DIGIT-1:0]),
    .cin   (carry),
    .sum   (dsum),
    .cout  (dcout),
    .c_msb (dcmsb)
  );

  // Each new digit enters the result from the MSB side, so after N digits
  // the first one has reached bit 0.
  if (DIGIT == WIDTH) begin : g_res_full
    assign res_nxt = dsum;
  end else begin : g_res_shift
    assign res_nxt = {dsum, res_q[WIDTH-1:DIGIT]};
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_digit = (state == RUN) && (cnt == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_digit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      res_q   <= '0;
      carry   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        // Subtraction is a + ~b + 1: invert B once and seed the carry.
        a_sr  <= a;
        b_sr  <= b ^ {WIDTH{op_sub}};
        carry <= op_sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sr  <= a_sr >> DIGIT;
        b_sr  <= b_sr >> DIGIT;
        res_q <= res_nxt;
        carry <= dcout;
        cnt   <= cnt + 1'b1;
        if (cnt == LAST) begin
          carry_q <= dcout;
          ovf_q   <= dcmsb ^ dcout;
          zero_q  <= (res_nxt == '0);
        end
      end
    end
  end

  assign result    = res_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Scoreboard bench for serial_add_sub_unit: W4/D1, W8/D4 and W8/D8 instances.
module tb_serial_add_sub_unit;
  import add_sub_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       op_sub;
  logic       out_ready;
  logic       iv0, iv1, iv2;

  logic       ir0, ov0, c0, v0, z0;
  logic [3:0] r0;
  logic       ir1, ov1, c1, v1, z1;
  logic [7:0] r1;
  logic       ir2, ov2, c2, v2, z2;
  logic [7:0] r2;

  serial_add_sub_unit #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op_sub(op_sub),
    .a(a[3:0]), .b(b[3:0]), .out_valid(ov0), .out_ready(out_ready),
    .result(r0), .carry_out(c0), .overflow(v0), .zero(z0)
  );

  serial_add_sub_unit #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready),
    .result(r1), .carry_out(c1), .overflow(v1), .zero(z1)
  );

  serial_add_sub_unit #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op_sub(op_sub),
    .a(a), .b(b), .out_valid(ov2), .out_ready(out_ready),
    .result(r2), .carry_out(c2), .overflow(v2), .zero(z2)
  );

  // Instance selected by the driver tasks.
  int         sel;
  logic       cur_ir, cur_ov, cur_c, cur_v, cur_z;
  logic [7:0] cur_r;

  always_comb begin
    cur_ir = ir0; cur_ov = ov0; cur_c = c0; cur_v = v0; cur_z = z0; cur_r = {4'h0, r0};
    case (sel)
      1: begin cur_ir = ir1; cur_ov = ov1; cur_c = c1; cur_v = v1; cur_z = z1; cur_r = r1; end
      2: begin cur_ir = ir2; cur_ov = ov2; cur_c = c2; cur_v = v2; cur_z = z2; cur_r = r2; end
      default: ;
    endcase
  end

  function automatic int width_of(input int s);
    return (s == 0) ? 4 : 8;
  endfunction

  function automatic int digits_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 2 : 1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];   // {result[7:0], carry_out, overflow, zero}
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (sel=%0d): got %0h expected %0h", tag, sel, got, exp);
  endtask

  // Reference: unsigned arithmetic for result/carry, sign rules for overflow.
  function automatic logic [10:0] model(input int w, input logic op, input logic [7:0] x, input logic [7:0] y);
    int   mask, ua, ub, r;
    logic c, v, z, sa, sb, sr;
    mask = (1 << w) - 1;
    ua = int'(x) & mask;
    ub = int'(y) & mask;
    if (op == OP_ADD) begin
      r = ua + ub;
      c = (r > mask);
    end else begin
      r = ua - ub;
      c = (ua >= ub);
    end
    r  = r & mask;
    sa = ((ua >> (w - 1)) & 1) != 0;
    sb = ((ub >> (w - 1)) & 1) != 0;
    sr = ((r  >> (w - 1)) & 1) != 0;
    if (op == OP_ADD) v = (sa == sb) && (sr != sa);
    else              v = (sa != sb) && (sr != sa);
    z = (r == 0);
    return {r[7:0], c, v, z};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_iv(input logic v);
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0;
    case (sel)
      0: iv0 = v;
      1: iv1 = v;
      default: iv2 = v;
    endcase
  endtask

  task automatic run_op(input logic op, input logic [7:0] x, input logic [7:0] y, input int hold);
    int          lat;
    logic [10:0] e;
    exp_q.push_back(model(width_of(sel), op, x, y));
    @(negedge clk);
    a = x; b = y; op_sub = op;
    set_iv(1'b1);
    check("in_ready_idle", cur_ir, 1);
    @(posedge clk);
    @(negedge clk);
    set_iv(1'b0);
    lat = 0;
    while (!cur_ov && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, digits_of(sel));
    e = exp_q.pop_front();
    check("result",    cur_r, e[10:3]);
    check("carry_out", cur_c, e[2]);
    check("overflow",  cur_v, e[1]);
    check("zero",      cur_z, e[0]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = ~x; b = ~y; op_sub = ~op;
      set_iv(1'b1);
      check("hold_out_valid", cur_ov, 1);
      check("hold_in_ready",  cur_ir, 0);
      check("hold_result",    cur_r, e[10:3]);
      check("hold_flags",     {cur_c, cur_v, cur_z}, e[2:0]);
    end
    set_iv(1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", cur_ov, 0);
    check("in_ready_back",  cur_ir, 1);
  endtask

  task automatic reset_mid_op(input logic op, input logic [7:0] x, input logic [7:0] y);
    logic seen;
    @(negedge clk);
    a = x; b = y; op_sub = op;
    set_iv(1'b1);
    @(posedge clk);          // accept
    @(negedge clk);
    set_iv(1'b0);
    @(posedge clk);          // first RUN edge
    @(negedge clk);
    rst_n = 1'b0;            // sampled at the end of the 2nd RUN cycle
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_valid", cur_ov, 0);
    check("rst_in_ready",  cur_ir, 1);
    check("rst_result",    cur_r, 0);
    check("rst_flags",     {cur_c, cur_v, cur_z}, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (cur_ov) seen = 1'b1;
    end
    check("aborted_no_out_valid", seen, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; a = '0; b = '0; op_sub = OP_ADD; out_ready = 1'b0;
    iv0 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_in_ready",  cur_ir, 1);
      check("reset_out_valid", cur_ov, 0);
      check("reset_result",    cur_r, 0);
      check("reset_flags",     {cur_c, cur_v, cur_z}, 0);
    end

    sel = 0;
    run_op(OP_ADD, 8'h03, 8'h05, 0);
    run_op(OP_SUB, 8'h05, 8'h03, 0);
    run_op(OP_SUB, 8'h03, 8'h05, 0);
    run_op(OP_SUB, 8'h08, 8'h01, 0);
    run_op(OP_SUB, 8'h06, 8'h06, 0);
    run_op(OP_ADD, 8'h07, 8'h09, 5);     // backpressure with in_valid pulses
    reset_mid_op(OP_ADD, 8'h03, 8'h05);
    run_op(OP_SUB, 8'h05, 8'h03, 0);

    sel = 1;
    run_op(OP_ADD, 8'hFF, 8'h01, 0);
    run_op(OP_SUB, 8'h80, 8'h01, 0);
    sel = 2;
    run_op(OP_ADD, 8'h7F, 8'h01, 0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      repeat (25)
        run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
